// File: rtl/timelyrv_peri_timer_irq.sv
// rtl/timelyrv_peri_timer_irq.sv - machine timer and interrupt aggregator on the peripheral bus
//
// Purpose: decodes peripheral-bus requests in a 4 KiB window and serves a
// 64-bit mtime/mtimecmp timer, a software-interrupt bit and 16 edge-latched
// fast interrupt sources, folded into the core's 32-bit irq_bitmap.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   peri_rden, peri_wren     read / write request (held until granted)
//   peri_addr, peri_wdata    byte address, write data
//   peri_wstrb               per-byte write enables
//   peri_rdata, peri_ready   registered response beat, one cycle after grant
//   peri_gnt                 combinational grant on window hit
//   irq_ack_i, irq_id_i      core interrupt acknowledge and its id
//   ext_irq                  level external interrupt
//   fast_irq                 rising-edge fast interrupt sources
//   irq_bitmap               registered interrupt vector to the core
module timelyrv_peri_timer_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        peri_rden,
  input  logic        peri_wren,
  input  logic [31:0] peri_addr,
  input  logic [31:0] peri_wdata,
  input  logic [3:0]  peri_wstrb,
  output logic [31:0] peri_rdata,
  output logic        peri_ready,
  output logic        peri_gnt,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i,
  input  logic        ext_irq,
  input  logic [15:0] fast_irq,
  output logic [31:0] irq_bitmap
);

  localparam logic [31:0] PRESC_MAX = 32'(PRESCALE - 1);

  localparam logic [9:0] OFF_MTIME_LO    = 10'd0;
  localparam logic [9:0] OFF_MTIME_HI    = 10'd1;
  localparam logic [9:0] OFF_MTIMECMP_LO = 10'd2;
  localparam logic [9:0] OFF_MTIMECMP_HI = 10'd3;
  localparam logic [9:0] OFF_CTRL        = 10'd4;
  localparam logic [9:0] OFF_MSIP        = 10'd5;
  localparam logic [9:0] OFF_PENDING     = 10'd6;
  localparam logic [9:0] OFF_ENABLE      = 10'd7;
  localparam logic [9:0] OFF_LAST_ACK    = 10'd8;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] presc_q, presc_d;
  logic        ctrl_q, ctrl_d;
  logic        msip_q, msip_d;
  logic [15:0] pending_q, pending_d;
  logic [15:0] enable_q, enable_d;
  logic [4:0]  last_ack_q, last_ack_d;
  logic [31:0] shadow_q, shadow_d;
  logic [15:0] fast_q, fast_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic [31:0] bitmap_q, bitmap_d;

  logic        hit;
  logic        wr_en;
  logic        rd_en;
  logic [9:0]  woff;
  logic [31:0] rd_val;
  logic [31:0] wr_old;
  logic [31:0] wr_val;
  logic [15:0] fast_edge;
  logic [15:0] w1c_mask;
  logic [15:0] ack_mask;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return r;
  endfunction

  assign hit              = (peri_addr[31:12] == BASE_ADDR[31:12]);
  assign peri_gnt         = hit & (peri_rden | peri_wren);
  assign wr_en            = peri_gnt & peri_wren;
  assign rd_en            = peri_gnt & peri_rden & ~peri_wren;
  assign woff             = peri_addr[11:2];
  assign unused_addr_bits = ^peri_addr[1:0];

  // One register stage: an edge is "high now, low last cycle".
  assign fast_edge = fast_irq & ~fast_q;
  assign fast_d    = fast_irq;

  always_comb begin
    rd_val = '0;
    case (woff)
      OFF_MTIME_LO:    rd_val = mtime_q[31:0];
      OFF_MTIME_HI:    rd_val = shadow_q;
      OFF_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
      OFF_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
      OFF_CTRL:        rd_val = {31'b0, ctrl_q};
      OFF_MSIP:        rd_val = {31'b0, msip_q};
      OFF_PENDING:     rd_val = {16'b0, pending_q};
      OFF_ENABLE:      rd_val = {16'b0, enable_q};
      OFF_LAST_ACK:    rd_val = {27'b0, last_ack_q};
      default:         rd_val = '0;
    endcase
  end

  // MTIME_HI reads the shadow, so its byte merge needs the live upper half.
  assign wr_old = (woff == OFF_MTIME_HI) ? mtime_q[63:32] : rd_val;
  assign wr_val = merge_bytes(wr_old, peri_wdata, peri_wstrb);

  assign w1c_mask = (wr_en && woff == OFF_PENDING)
                  ? (peri_wdata[15:0] & {{8{peri_wstrb[1]}}, {8{peri_wstrb[0]}}})
                  : 16'b0;

  always_comb begin
    ack_mask = '0;
    if (irq_ack_i && irq_id_i[4]) ack_mask[irq_id_i[3:0]] = 1'b1;
  end

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    presc_d    = presc_q;
    ctrl_d     = ctrl_q;
    msip_d     = msip_q;
    enable_d   = enable_q;
    last_ack_d = last_ack_q;
    shadow_d   = shadow_q;

    if (ctrl_q) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        presc_d = presc_q + 32'd1;
      end
    end

    // Software writes to mtime override any tick this cycle.
    if (wr_en) begin
      case (woff)
        OFF_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], wr_val};
          presc_d = '0;
        end
        OFF_MTIME_HI: begin
          mtime_d = {wr_val, mtime_q[31:0]};
          presc_d = '0;
        end
        OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = wr_val;
        OFF_MTIMECMP_HI: mtimecmp_d[63:32] = wr_val;
        OFF_CTRL:        ctrl_d   = wr_val[0];
        OFF_MSIP:        msip_d   = wr_val[0];
        OFF_ENABLE:      enable_d = wr_val[15:0];
        default: ;
      endcase
    end

    // Reading MTIME_LO freezes the upper half for a coherent 64-bit read.
    if (rd_en && woff == OFF_MTIME_LO) shadow_d = mtime_q[63:32];

    if (irq_ack_i) last_ack_d = irq_id_i;

    // A new edge beats any clear in the same cycle.
    pending_d = (pending_q & ~(w1c_mask | ack_mask)) | fast_edge;

    bitmap_d        = '0;
    bitmap_d[3]     = msip_q;
    bitmap_d[7]     = ctrl_q & (mtime_q >= mtimecmp_q);
    bitmap_d[11]    = ext_irq;
    bitmap_d[31:16] = pending_q & enable_q;

    ready_d = peri_gnt;
    rdata_d = rd_en ? rd_val : 32'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      ctrl_q     <= 1'b0;
      msip_q     <= 1'b0;
      pending_q  <= '0;
      enable_q   <= '0;
      last_ack_q <= '0;
      shadow_q   <= '0;
      fast_q     <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      bitmap_q   <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      ctrl_q     <= ctrl_d;
      msip_q     <= msip_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      last_ack_q <= last_ack_d;
      shadow_q   <= shadow_d;
      fast_q     <= fast_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      bitmap_q   <= bitmap_d;
    end
  end

  assign peri_rdata = rdata_q;
  assign peri_ready = ready_q;
  assign irq_bitmap = bitmap_q;

endmodule

// File: tb/tb_timelyrv_peri_timer_irq.sv
// tb/tb_timelyrv_peri_timer_irq.sv - self-checking bench for timelyrv_peri_timer_irq
module tb_timelyrv_peri_timer_irq;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int unsigned PRESC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        peri_rden;
  logic        peri_wren;
  logic [31:0] peri_addr;
  logic [31:0] peri_wdata;
  logic [3:0]  peri_wstrb;
  logic [31:0] peri_rdata;
  logic        peri_ready;
  logic        peri_gnt;
  logic        irq_ack_i;
  logic [4:0]  irq_id_i;
  logic        ext_irq;
  logic [15:0] fast_irq;
  logic [31:0] irq_bitmap;

  always #5 clk = ~clk;

  timelyrv_peri_timer_irq #(
    .BASE_ADDR(BASE),
    .PRESCALE (PRESC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .peri_rden  (peri_rden),
    .peri_wren  (peri_wren),
    .peri_addr  (peri_addr),
    .peri_wdata (peri_wdata),
    .peri_wstrb (peri_wstrb),
    .peri_rdata (peri_rdata),
    .peri_ready (peri_ready),
    .peri_gnt   (peri_gnt),
    .irq_ack_i  (irq_ack_i),
    .irq_id_i   (irq_id_i),
    .ext_irq    (ext_irq),
    .fast_irq   (fast_irq),
    .irq_bitmap (irq_bitmap)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: mtime is the last written base plus whole prescale
  // periods of enabled cycles counted since that write.
  logic [63:0] m_base;
  int unsigned m_cnt;
  logic [63:0] m_cmp;
  logic        m_ctrl;
  logic        m_msip;
  logic [15:0] m_pend;
  logic [15:0] m_en;
  logic [4:0]  m_last;
  logic [31:0] m_shadow;
  logic [15:0] m_fprev;
  logic        exp_ready;
  logic [31:0] exp_rdata;
  logic [31:0] exp_bitmap;
  logic [31:0] rd_word;
  logic [31:0] rd_lo;
  logic [31:0] rd_hi;
  int          n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bytes_apply(input logic [31:0] old_v,
                                              input logic [31:0] wd,
                                              input logic [3:0]  st);
    logic [31:0] mask;
    mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (old_v & ~mask) | (wd & mask);
  endfunction

  function automatic logic [63:0] m_mtime();
    return m_base + 64'(m_cnt / PRESC);
  endfunction

  function automatic logic [31:0] m_read(input int w);
    logic [63:0] now;
    now = m_mtime();
    case (w)
      0: return now[31:0];
      1: return m_shadow;
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return {31'b0, m_ctrl};
      5: return {31'b0, m_msip};
      6: return {16'b0, m_pend};
      7: return {16'b0, m_en};
      8: return {27'b0, m_last};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_step();
    logic        gnt;
    logic        wr;
    logic        rd;
    int          w;
    logic [63:0] now;
    logic [31:0] nb;
    logic [31:0] tmp;
    logic [15:0] clr;
    logic [15:0] set;
    if (rst) begin
      m_base = '0; m_cnt = 0; m_cmp = '1; m_ctrl = 0; m_msip = 0;
      m_pend = '0; m_en = '0; m_last = '0; m_shadow = '0; m_fprev = '0;
      exp_ready = 0; exp_rdata = '0; exp_bitmap = '0;
      return;
    end
    gnt = (peri_addr[31:12] == BASE[31:12]) && (peri_rden || peri_wren);
    wr  = gnt && peri_wren;
    rd  = gnt && peri_rden && !peri_wren;
    w   = int'(peri_addr[11:2]);
    now = m_mtime();

    nb        = '0;
    nb[3]     = m_msip;
    nb[7]     = m_ctrl && (now >= m_cmp);
    nb[11]    = ext_irq;
    nb[31:16] = m_pend & m_en;
    exp_bitmap = nb;
    exp_ready  = gnt;
    exp_rdata  = rd ? m_read(w) : 32'b0;

    if (m_ctrl) m_cnt++;
    set     = fast_irq & ~m_fprev;
    m_fprev = fast_irq;
    clr     = '0;
    if (irq_ack_i) begin
      m_last = irq_id_i;
      if (irq_id_i >= 5'd16) clr[irq_id_i[3:0]] = 1'b1;
    end
    if (rd && w == 0) m_shadow = now[63:32];
    if (wr) begin
      case (w)
        0: begin m_base = {now[63:32], bytes_apply(now[31:0], peri_wdata, peri_wstrb)}; m_cnt = 0; end
        1: begin m_base = {bytes_apply(now[63:32], peri_wdata, peri_wstrb), now[31:0]}; m_cnt = 0; end
        2: m_cmp[31:0]  = bytes_apply(m_cmp[31:0], peri_wdata, peri_wstrb);
        3: m_cmp[63:32] = bytes_apply(m_cmp[63:32], peri_wdata, peri_wstrb);
        4: if (peri_wstrb[0]) m_ctrl = peri_wdata[0];
        5: if (peri_wstrb[0]) m_msip = peri_wdata[0];
        6: begin
          tmp = bytes_apply(32'b0, peri_wdata, peri_wstrb);
          clr = clr | tmp[15:0];
        end
        7: begin
          tmp  = bytes_apply({16'b0, m_en}, peri_wdata, peri_wstrb);
          m_en = tmp[15:0];
        end
        default: ;
      endcase
    end
    m_pend = (m_pend & ~clr) | set;
  endtask

  task automatic tick();
    logic exp_gnt;
    #1;
    exp_gnt = (peri_addr[31:12] == BASE[31:12]) && (peri_rden || peri_wren);
    chk("gnt", {31'b0, peri_gnt}, {31'b0, exp_gnt});
    model_step();
    @(posedge clk);
    #1;
    chk("ready", {31'b0, peri_ready}, {31'b0, exp_ready});
    chk("rdata", peri_rdata, exp_rdata);
    chk("bitmap", irq_bitmap, exp_bitmap);
  endtask

  task automatic bus_write(input logic [9:0] w, input logic [31:0] d, input logic [3:0] s);
    peri_addr  = BASE | {20'b0, w, 2'b00};
    peri_wdata = d;
    peri_wstrb = s;
    peri_wren  = 1'b1;
    tick();
    peri_wren  = 1'b0;
  endtask

  task automatic bus_read(input logic [9:0] w, output logic [31:0] d);
    peri_addr = BASE | {20'b0, w, 2'b00};
    peri_rden = 1'b1;
    tick();
    d = peri_rdata;
    peri_rden = 1'b0;
  endtask

  initial begin
    rst = 1'b1; peri_rden = 0; peri_wren = 0; peri_addr = '0; peri_wdata = '0;
    peri_wstrb = '0; irq_ack_i = 0; irq_id_i = '0; ext_irq = 0; fast_irq = '0;
    @(posedge clk); #1;
    tick();
    tick();
    rst = 1'b0;

    bus_read(10'd3, rd_word);
    chk("rst_mtimecmp_hi", rd_word, 32'hFFFF_FFFF);
    chk("rst_bitmap", irq_bitmap, 32'h0);

    bus_write(10'd2, 32'd3, 4'hF);
    bus_write(10'd3, 32'd0, 4'hF);
    bus_write(10'd4, 32'd1, 4'hF);
    n = 0;
    while (!irq_bitmap[7] && n < 100) begin
      tick();
      n++;
    end
    chk("timer_rise_cycles", 32'(n), 32'd13);
    bus_write(10'd3, 32'd1, 4'hF);
    tick();
    chk("timer_fall", {31'b0, irq_bitmap[7]}, 32'd0);

    bus_write(10'd4, 32'd0, 4'hF);
    bus_write(10'd1, 32'hFFFF_FFFF, 4'hF);
    bus_write(10'd0, 32'hFFFF_FFFF, 4'hF);
    bus_read(10'd0, rd_lo);
    bus_read(10'd1, rd_hi);
    chk("frozen_lo", rd_lo, 32'hFFFF_FFFF);
    chk("frozen_hi", rd_hi, 32'hFFFF_FFFF);
    bus_write(10'd4, 32'd1, 4'hF);
    repeat (6) tick();
    bus_read(10'd0, rd_lo);
    bus_read(10'd1, rd_hi);
    chk("wrap_lo", rd_lo, 32'd0);
    chk("wrap_hi", rd_hi, 32'd0);

    bus_write(10'd7, 32'h0000_0001, 4'hF);
    fast_irq = 16'h0001;
    tick();
    fast_irq = 16'h0000;
    tick();
    chk("fast_lag2", {31'b0, irq_bitmap[16]}, 32'd1);
    irq_ack_i = 1'b1; irq_id_i = 5'd16;
    tick();
    irq_ack_i = 1'b0; irq_id_i = 5'd0;
    tick();
    chk("ack_clear", {31'b0, irq_bitmap[16]}, 32'd0);
    bus_read(10'd8, rd_word);
    chk("last_ack", rd_word, 32'd16);
    fast_irq = 16'h0001;
    tick();
    fast_irq = 16'h0000;
    tick();
    fast_irq = 16'h0001;
    bus_write(10'd6, 32'h0000_0001, 4'hF);
    fast_irq = 16'h0000;
    bus_read(10'd6, rd_word);
    chk("set_beats_w1c", rd_word, 32'd1);
    bus_write(10'd6, 32'h0000_0001, 4'hF);

    bus_write(10'd5, 32'd1, 4'b0010);
    bus_read(10'd5, rd_word);
    chk("msip_wrong_strb", rd_word, 32'd0);
    bus_write(10'd5, 32'd1, 4'b0001);
    tick();
    chk("msip_bitmap", {31'b0, irq_bitmap[3]}, 32'd1);

    peri_addr = 32'h0000_0100;
    peri_rden = 1'b1;
    tick();
    peri_rden = 1'b0;
    chk("miss_ready", {31'b0, peri_ready}, 32'd0);
    bus_read(10'd16, rd_word);
    chk("hole_rdata", rd_word, 32'd0);
    chk("hole_ready", {31'b0, peri_ready}, 32'd1);

    peri_addr = BASE | 32'h0C;
    peri_rden = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    peri_rden = 1'b0;
    chk("rst_drop_ready", {31'b0, peri_ready}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      int kind;
      kind      = int'($urandom_range(0, 3));
      peri_rden = 1'b0;
      peri_wren = 1'b0;
      peri_addr = BASE | {20'b0, 10'($urandom_range(0, 10)), 2'b00};
      if (kind == 1) peri_rden = 1'b1;
      if (kind == 2) peri_wren = 1'b1;
      if (kind == 3) begin
        peri_addr = {$urandom} & 32'h0FFF_FFFC;
        peri_rden = 1'b1;
      end
      peri_wdata = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      peri_wstrb = 4'($urandom_range(0, 15));
      fast_irq   = 16'($urandom);
      ext_irq    = 1'($urandom_range(0, 1));
      irq_ack_i  = ($urandom_range(0, 3) == 0);
      irq_id_i   = 5'($urandom_range(0, 31));
      tick();
    end
    peri_rden = 1'b0;
    peri_wren = 1'b0;
    irq_ack_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
